// File: rtl/acorn128_pkg.sv
// Shared types and widths for the ACORN-128 decrypt-and-verify controller.
// Imported by the controller top and its tag comparator.
package acorn128_pkg;

  localparam int KEY_W = 128;
  localparam int BLK_W = 128;
  localparam int TAG_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    CORE_RST,
    LAUNCH,
    WAIT_RDY,
    COMPARE,
    RESP
  } ctrl_state_e;

endpackage

// File: rtl/acorn128_tag_cmp.sv
// Constant-time tag equality: every bit pair is XORed and the full vector OR-reduced,
// so the evaluation path never depends on where (or whether) the tags differ.
module acorn128_tag_cmp
  import acorn128_pkg::*;
(
  input  logic [TAG_W-1:0] tag_a,
  input  logic [TAG_W-1:0] tag_b,
  output logic             match
);

  logic [TAG_W-1:0] diff_bits;

  assign diff_bits = tag_a ^ tag_b;
  assign match     = ~(|diff_bits);

endmodule

// File: rtl/acorn128_decrypt_ctrl.sv
// Host-side controller that resets, launches and waits on an ACORN-128 core in decrypt
// mode, then releases plaintext only when the computed tag matches the received one.
module acorn128_decrypt_ctrl
  import acorn128_pkg::*;
#(
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int LEN_W          = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [BLK_W-1:0]  iv_in,
  input  logic [BLK_W-1:0]  ad_in,
  input  logic [BLK_W-1:0]  ct_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [LEN_W-1:0]  length_in,
  output logic              core_rst_out,
  output logic              core_start_out,
  output logic              core_encrypt_out,
  output logic [KEY_W-1:0]  core_key_out,
  output logic [BLK_W-1:0]  core_iv_out,
  output logic [BLK_W-1:0]  core_ad_out,
  output logic [BLK_W-1:0]  core_ct_out,
  output logic [LEN_W-1:0]  core_len_out,
  input  logic [BLK_W-1:0]  core_data_in,
  input  logic [TAG_W-1:0]  core_tag_in,
  input  logic              core_ready_in,
  output logic              resp_valid_out,
  input  logic              resp_ready_in,
  output logic [BLK_W-1:0]  pt_out,
  output logic              auth_ok_out,
  output logic              timeout_out
);

  localparam int CNT_W = $clog2(RST_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_e state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic [KEY_W-1:0] key_q;
  logic [BLK_W-1:0] iv_q;
  logic [BLK_W-1:0] ad_q;
  logic [BLK_W-1:0] ct_q;
  logic [TAG_W-1:0] tag_rx_q;
  logic [LEN_W-1:0] len_q;
  logic [BLK_W-1:0] data_q;
  logic [TAG_W-1:0] tag_core_q;
  logic [BLK_W-1:0] pt_q;
  logic             auth_q;
  logic             timeout_q;
  logic             tag_match;
  logic             accept;

  acorn128_tag_cmp u_tag_cmp (
    .tag_a (tag_core_q),
    .tag_b (tag_rx_q),
    .match (tag_match)
  );

  assign accept           = req_valid_in && req_ready_out;
  assign core_encrypt_out = 1'b0;
  assign core_key_out     = key_q;
  assign core_iv_out      = iv_q;
  assign core_ad_out      = ad_q;
  assign core_ct_out      = ct_q;
  assign core_len_out     = len_q;
  assign pt_out           = pt_q;
  assign auth_ok_out      = auth_q;
  assign timeout_out      = timeout_q;

  always_comb begin
    state_next     = state;
    req_ready_out  = 1'b0;
    core_rst_out   = 1'b0;
    core_start_out = 1'b0;
    resp_valid_out = 1'b0;
    case (state)
      IDLE: begin
        req_ready_out = 1'b1;
        core_rst_out  = 1'b1;
        if (req_valid_in) state_next = CORE_RST;
      end
      CORE_RST: begin
        core_rst_out = 1'b1;
        if (cnt == '0) state_next = LAUNCH;
      end
      LAUNCH: begin
        core_start_out = 1'b1;
        state_next     = WAIT_RDY;
      end
      WAIT_RDY: begin
        // A ready on the final timeout cycle still wins over the abort.
        if (core_ready_in)    state_next = COMPARE;
        else if (tmo == '0)   state_next = RESP;
      end
      COMPARE: state_next = RESP;
      RESP: begin
        resp_valid_out = 1'b1;
        if (resp_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tmo        <= '0;
      key_q      <= '0;
      iv_q       <= '0;
      ad_q       <= '0;
      ct_q       <= '0;
      tag_rx_q   <= '0;
      len_q      <= '0;
      data_q     <= '0;
      tag_core_q <= '0;
      pt_q       <= '0;
      auth_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            key_q    <= key_in;
            iv_q     <= iv_in;
            ad_q     <= ad_in;
            ct_q     <= ct_in;
            tag_rx_q <= tag_in;
            len_q    <= length_in;
            cnt      <= CNT_LOAD;
          end
        end
        CORE_RST: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        LAUNCH: tmo <= TMO_LOAD;
        WAIT_RDY: begin
          if (core_ready_in) begin
            data_q     <= core_data_in;
            tag_core_q <= core_tag_in;
          end else if (tmo == '0) begin
            timeout_q <= 1'b1;
            auth_q    <= 1'b0;
            pt_q      <= '0;
          end else begin
            tmo <= tmo - TMO_W'(1);
          end
        end
        COMPARE: begin
          auth_q <= tag_match;
          pt_q   <= tag_match ? data_q : '0;
        end
        RESP: begin
          // Scrub the result once delivered so nothing lingers on pt_out while idle.
          if (resp_ready_in) begin
            pt_q      <= '0;
            auth_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
